// File: rtl/led_pwm_driver_pkg.sv
// Shared constants for the LED PWM driver: led_in field layout and a width helper.
package led_pkg;

  localparam int LED_COUNT   = 4;
  localparam int LED_EN_LSB  = 0;
  localparam int LED_LVL_LSB = 4;
  localparam int LED_IN_W    = 8;

  // Counter width needed to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_pwm_driver_timebase.sv
// Free-running prescaler and PWM counter; flags the last tick of every PWM period.
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int PRESCALE = 64,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                bnd,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;

  // With PRESCALE=1 presc is pinned at 0, so tick is constantly high.
  assign tick = (presc == PRESC_LAST);
  assign bnd  = tick && (&pwm_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Four-channel LED PWM driver: enables and target brightness sampled once per period,
// applied brightness ramps one step per period toward the target.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE = 64,
  parameter int PWM_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LED_IN_W-1:0]  led_in,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 period_start,
  output logic [PWM_BITS-1:0]  level
);

  logic                 bnd;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  tgt;
  logic [PWM_BITS-1:0]  level_nxt;
  logic [LED_COUNT-1:0] en;
  logic                 unused_led_in;

  led_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk     (clk),
    .reset   (reset),
    .bnd     (bnd),
    .pwm_cnt (pwm_cnt)
  );

  // Narrow PWM_BITS take only the top bits of the brightness nibble.
  assign tgt           = led_in[LED_IN_W-1 -: PWM_BITS];
  assign unused_led_in = ^led_in;

  always_comb begin
    level_nxt = level;
    if (tgt > level)      level_nxt = level + 1'b1;
    else if (tgt < level) level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en           <= '0;
      level        <= '0;
      led_out      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= bnd;
      led_out      <= en & {LED_COUNT{pwm_cnt <= level}};
      if (bnd) begin
        en    <= led_in[LED_EN_LSB +: LED_COUNT];
        level <= level_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed, table-driven bench for led_pwm_driver: one instance at PRESCALE=4/PWM_BITS=4,
// one at PRESCALE=1/PWM_BITS=2. Each vector covers one PWM period.
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic [7:0] led_in_a, led_in_b;
  logic [3:0] led_out_a, led_out_b;
  logic       period_start_a, period_start_b;
  logic [3:0] level_a;
  logic [1:0] level_b;

  always #5 clk = ~clk;

  led_pwm_driver #(.PRESCALE(4), .PWM_BITS(4)) dut_a (
    .clk          (clk),
    .reset        (reset_a),
    .led_in       (led_in_a),
    .led_out      (led_out_a),
    .period_start (period_start_a),
    .level        (level_a)
  );

  led_pwm_driver #(.PRESCALE(1), .PWM_BITS(2)) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .led_in       (led_in_b),
    .led_out      (led_out_b),
    .period_start (period_start_b),
    .level        (level_b)
  );

  typedef struct {
    logic [7:0] led_in;
    int         lvl;
    int         c0, c1, c2, c3;
  } vec_t;

  vec_t vecs[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   w_cnt[4];
  int   w_ps, w_lvl, w_first, w_last;

  function automatic vec_t mk(input logic [7:0] li, input int lvl,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.led_in = li; v.lvl = lvl;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts aligned with a period start (just after a boundary edge, on a negedge);
  // the len samples cover exactly one period of the selected instance.
  task automatic run_window(input bit use_b, input int len, input int chg_at,
                            input logic [7:0] chg_val);
    logic [3:0] cur;
    logic       ps;
    for (int j = 0; j < 4; j++) w_cnt[j] = 0;
    w_ps = 0; w_first = -1; w_last = -1; w_lvl = -1;
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) led_in_a = chg_val;
      @(negedge clk);
      cur = use_b ? led_out_b : led_out_a;
      ps  = use_b ? period_start_b : period_start_a;
      if (i == 0) w_lvl = use_b ? int'(level_b) : int'(level_a);
      for (int j = 0; j < 4; j++) w_cnt[j] += int'(cur[j]);
      w_ps += int'(ps);
      if (cur[0]) begin
        if (w_first < 0) w_first = i;
        w_last = i;
      end
    end
  endtask

  task automatic check_window(input string tag, input vec_t v, input int exp_ps);
    check({tag, " level"}, w_lvl, v.lvl);
    check({tag, " on0"}, w_cnt[0], v.c0);
    check({tag, " on1"}, w_cnt[1], v.c1);
    check({tag, " on2"}, w_cnt[2], v.c2);
    check({tag, " on3"}, w_cnt[3], v.c3);
    check({tag, " period_start"}, w_ps, exp_ps);
    if (v.c0 > 0) begin
      check({tag, " first_on0"}, w_first, 0);
      check({tag, " last_on0"}, w_last, v.c0 - 1);
    end
  endtask

  task automatic apply_row_a(input vec_t v, input int idx);
    led_in_a = v.led_in;
    run_window(1'b0, 64, -1, 8'h00);
    check_window($sformatf("a_row%0d", idx), v, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // Ramp up 0->15 with only LED0 enabled; period 0 has en=0.
    vecs.push_back(mk(8'hF1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 15; k++) vecs.push_back(mk(8'hF1, k, 4 * (k + 1), 0, 0, 0));
    // Hold at 15 while the new value (all enabled, target 0) is sampled.
    vecs.push_back(mk(8'h0F, 15, 64, 0, 0, 0));
    for (int j = 1; j <= 15; j++) begin
      vecs.push_back(mk(8'h0F, 15 - j, 4 * (16 - j), 4 * (16 - j), 4 * (16 - j), 4 * (16 - j)));
    end
    // Level 0 floor, then ramp to 8 on LED0 and sit there three periods.
    vecs.push_back(mk(8'h81, 0, 4, 4, 4, 4));
    for (int m = 1; m <= 7; m++) vecs.push_back(mk(8'h81, m, 4 * (m + 1), 0, 0, 0));
    for (int r = 0; r < 3; r++) vecs.push_back(mk(8'h81, 8, 36, 0, 0, 0));

    reset_a  = 1'b1;
    reset_b  = 1'b1;
    led_in_a = 8'hFF;
    led_in_b = 8'hC3;
    repeat (3) @(negedge clk);
    check("hold_reset led_out_a", int'(led_out_a), 0);
    check("hold_reset level_a", int'(level_a), 0);
    check("hold_reset period_start_a", int'(period_start_a), 0);
    check("hold_reset led_out_b", int'(led_out_b), 0);

    led_in_a = 8'hF1;
    reset_a  = 1'b0;
    for (int i = 0; i < vecs.size(); i++) apply_row_a(vecs[i], i);

    // led_in changes 0x81 -> 0x82 at cycle 20; nothing moves until the boundary.
    v = mk(8'h81, 8, 36, 0, 0, 0);
    run_window(1'b0, 64, 20, 8'h82);
    check_window("a_midchg", v, 1);
    v = mk(8'h82, 8, 0, 36, 0, 0);
    run_window(1'b0, 64, -1, 8'h00);
    check_window("a_after_chg", v, 1);

    // Async reset mid-period while LED1 is lit: outputs drop before the next edge.
    repeat (10) @(negedge clk);
    check("pre_reset led1", int'(led_out_a[1]), 1);
    #1 reset_a = 1'b1;
    #1;
    check("async_reset led_out_a", int'(led_out_a), 0);
    check("async_reset level_a", int'(level_a), 0);
    check("async_reset period_start_a", int'(period_start_a), 0);
    led_in_a = 8'hFF;
    repeat (5) @(negedge clk);
    check("reset_held led_out_a", int'(led_out_a), 0);
    check("reset_held level_a", int'(level_a), 0);
    reset_a = 1'b0;
    apply_row_a(mk(8'hFF, 0, 0, 0, 0, 0), 100);
    apply_row_a(mk(8'hFF, 1, 8, 8, 8, 8), 101);
    apply_row_a(mk(8'hFF, 2, 12, 12, 12, 12), 102);

    // PRESCALE=1, PWM_BITS=2: 4-cycle periods, target 3, LEDs 0 and 1 enabled.
    reset_b = 1'b0;
    run_window(1'b1, 4, -1, 8'h00);
    check_window("b_p0", mk(8'hC3, 0, 0, 0, 0, 0), 1);
    run_window(1'b1, 4, -1, 8'h00);
    check_window("b_p1", mk(8'hC3, 1, 2, 2, 0, 0), 1);
    run_window(1'b1, 4, -1, 8'h00);
    check_window("b_p2", mk(8'hC3, 2, 3, 3, 0, 0), 1);
    run_window(1'b1, 4, -1, 8'h00);
    check_window("b_p3", mk(8'hC3, 3, 4, 4, 0, 0), 1);
    run_window(1'b1, 20, -1, 8'h00);
    check("b_steady level", w_lvl, 3);
    check("b_steady on0", w_cnt[0], 20);
    check("b_steady on1", w_cnt[1], 20);
    check("b_steady on2", w_cnt[2], 0);
    check("b_steady on3", w_cnt[3], 0);
    check("b_steady period_start", w_ps, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
